sample_scheduler: RTL and testbench

//  Sequences quantized and raw ADC samples into the 16-bit word stream consumed by packet_streamer.

---
 rtl/sample_scheduler_if.sv | 25 ++
 rtl/sample_scheduler.sv | 121 ++++++++++++
 tb/tb_sample_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_scheduler_if.sv
// Sample/word-stream bundle between the quantizer front end and packet_streamer.
// master drives the samples and requests; slave is the scheduler.
interface sample_scheduler_if;
  logic [11:0] q_samples;
  logic [7:0]  ch1_i;
  logic [7:0]  ch1_q;
  logic [7:0]  mode;
  logic        enable;
  logic [15:0] source_data;
  logic        source_en;
  logic        source_packet_end;
  logic [7:0]  active_mode;
  logic        busy;
  logic [15:0] packet_count;

  modport master (
    output q_samples, ch1_i, ch1_q, mode, enable,
    input  source_data, source_en, source_packet_end, active_mode, busy, packet_count
  );

  modport slave (
    input  q_samples, ch1_i, ch1_q, mode, enable,
    output source_data, source_en, source_packet_end, active_mode, busy, packet_count
  );
endinterface

// File: rtl/sample_scheduler.sv
// Packet-aligned scheduler packing quantized or raw ADC samples into 16-bit words.
// Mode and enable are only sampled in IDLE or on the last word of a packet.
module sample_scheduler #(
  parameter int WORDS_PER_PACKET = 720,
  parameter int WCW              = 10
) (
  input  logic              source_clk,
  input  logic              source_reset_n,
  sample_scheduler_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [27:0]     acc_q;
  logic [4:0]      bitcnt_q;
  logic [WCW-1:0]  wordcnt_q;
  logic [7:0]      prev_q;
  logic            half_q;
  logic [15:0]     data_q;
  logic            en_q;
  logic            end_q;
  logic [7:0]      mode_q;
  logic [15:0]     pkt_q;

  logic            mode_ok;
  logic [27:0]     acc_shift_d;
  logic [5:0]      bit_sum_d;
  logic [5:0]      shamt_d;
  logic [7:0]      raw_d;
  logic            word_valid_d;
  logic [15:0]     word_d;
  logic            last_word_d;

  always_comb begin
    mode_ok      = bus.mode < 8'd3;
    acc_shift_d  = (acc_q << 12) | {16'd0, bus.q_samples};
    bit_sum_d    = {1'b0, bitcnt_q} + 6'd12;
    // Only meaningful once at least 16 bits are buffered; the oldest bits sit highest.
    shamt_d      = bit_sum_d - 6'd16;
    raw_d        = (mode_q == 8'd2) ? bus.ch1_q : bus.ch1_i;
    last_word_d  = (wordcnt_q == WCW'(WORDS_PER_PACKET - 1));
    if (mode_q == 8'd0) begin
      word_valid_d = (bit_sum_d >= 6'd16);
      word_d       = 16'(acc_shift_d >> shamt_d);
    end else begin
      word_valid_d = half_q;
      word_d       = {prev_q, raw_d};
    end
  end

  always_ff @(posedge source_clk) begin
    if (!source_reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      bitcnt_q  <= '0;
      wordcnt_q <= '0;
      prev_q    <= '0;
      half_q    <= 1'b0;
      data_q    <= '0;
      en_q      <= 1'b0;
      end_q     <= 1'b0;
      mode_q    <= '0;
      pkt_q     <= '0;
    end else begin
      en_q   <= 1'b0;
      end_q  <= 1'b0;
      data_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.enable && mode_ok) begin
            mode_q    <= bus.mode;
            acc_q     <= '0;
            bitcnt_q  <= '0;
            wordcnt_q <= '0;
            half_q    <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (mode_q == 8'd0) begin
            acc_q    <= acc_shift_d;
            bitcnt_q <= word_valid_d ? 5'(shamt_d) : bit_sum_d[4:0];
          end else begin
            prev_q <= raw_d;
            half_q <= ~half_q;
          end
          if (word_valid_d) begin
            en_q   <= 1'b1;
            data_q <= word_d;
            if (last_word_d) begin
              end_q     <= 1'b1;
              wordcnt_q <= '0;
              pkt_q     <= pkt_q + 16'd1;
              // Back-to-back packets: re-arm on the same edge so no gap cycle appears.
              if (bus.enable && mode_ok) begin
                mode_q   <= bus.mode;
                acc_q    <= '0;
                bitcnt_q <= '0;
                half_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              wordcnt_q <= wordcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.source_data       = data_q;
  assign bus.source_en         = en_q;
  assign bus.source_packet_end = end_q;
  assign bus.active_mode       = mode_q;
  assign bus.busy              = (state_q == RUN);
  assign bus.packet_count      = pkt_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: constant-input vector table, packet-boundary sequences,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_sample_scheduler;
  localparam int WPP = 720;

  logic clk;
  logic rst_n;
  sample_scheduler_if bus ();

  sample_scheduler #(.WORDS_PER_PACKET(WPP), .WCW(10)) dut (
    .source_clk     (clk),
    .source_reset_n (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int word_cnt = 0;

  // Reference model: a bit queue (mode 0) or sample queue (modes 1/2) feeding words.
  bit          m_run;
  logic [7:0]  m_mode;
  bit          bq[$];
  logic [7:0]  sq[$];
  int          m_words;
  logic [15:0] m_pkts;
  logic [15:0] e_data;
  logic        e_en, e_end, e_busy;
  logic [7:0]  e_amode;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endfunction

  task automatic model_step();
    bit emit;
    logic [15:0] w;
    emit = 1'b0;
    w = '0;
    if (!rst_n) begin
      m_run = 1'b0; m_mode = '0; bq.delete(); sq.delete(); m_words = 0; m_pkts = '0;
      e_data = '0; e_en = 1'b0; e_end = 1'b0;
    end else begin
      e_data = '0; e_en = 1'b0; e_end = 1'b0;
      if (!m_run) begin
        if (bus.enable && bus.mode < 3) begin
          m_run = 1'b1; m_mode = bus.mode; bq.delete(); sq.delete(); m_words = 0;
        end
      end else begin
        if (m_mode == 8'd0) begin
          for (int b = 11; b >= 0; b--) bq.push_back(bus.q_samples[b]);
          if (bq.size() >= 16) begin
            for (int b = 0; b < 16; b++) w = {w[14:0], bq.pop_front()};
            emit = 1'b1;
          end
        end else begin
          sq.push_back((m_mode == 8'd1) ? bus.ch1_i : bus.ch1_q);
          if (sq.size() == 2) begin
            w[15:8] = sq.pop_front();
            w[7:0]  = sq.pop_front();
            emit = 1'b1;
          end
        end
        if (emit) begin
          e_en = 1'b1; e_data = w;
          if (m_words == WPP - 1) begin
            e_end = 1'b1; m_words = 0; m_pkts = m_pkts + 16'd1;
            if (bus.enable && bus.mode < 3) begin
              m_mode = bus.mode; bq.delete(); sq.delete();
            end else begin
              m_run = 1'b0;
            end
          end else begin
            m_words++;
          end
        end
      end
    end
    e_busy  = m_run;
    e_amode = m_mode;
  endtask

  task automatic step();
    logic [49:0] got, want;
    model_step();
    @(posedge clk);
    #1;
    got  = {bus.source_data, bus.source_en, bus.source_packet_end, bus.active_mode,
            bus.busy, bus.packet_count, 7'd0};
    want = {e_data, e_en, e_end, e_amode, e_busy, m_pkts, 7'd0};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL cycle_model t=%0t: got data=%h en=%b end=%b am=%0d busy=%b pc=%0d want data=%h en=%b end=%b am=%0d busy=%b pc=%0d",
               $time, bus.source_data, bus.source_en, bus.source_packet_end, bus.active_mode,
               bus.busy, bus.packet_count, e_data, e_en, e_end, e_amode, e_busy, m_pkts);
    end
    if (bus.source_en) word_cnt++;
    if (bus.source_en && bus.source_packet_end)
      $display("packet done: count=%0d mode=%0d", bus.packet_count, bus.active_mode);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.enable = 1'b0; bus.mode = '0;
    step(); step();
    rst_n = 1'b1;
    word_cnt = 0;
  endtask

  task automatic run_until_end(input int budget, output int endw);
    endw = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.source_en && bus.source_packet_end) begin
        endw = word_cnt;
        break;
      end
    end
  endtask

  task automatic run_until_words(input string name, input int n, input int budget);
    for (int i = 0; i < budget && word_cnt < n; i++) step();
    chk(name, word_cnt, n);
  endtask

  typedef struct {
    logic [7:0]  mode;
    logic [11:0] q;
    logic [7:0]  ri;
    logic [7:0]  rq;
    int          first;
    int          cnt;
    logic [15:0] w0, w1, w2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int endw, first, n, en_cnt;
    logic [15:0] got[3];
    logic [15:0] w0, w1;
    logic [7:0]  modes[5];

    vecs[0] = '{8'd0, 12'hABC, 8'h00, 8'h00, 3, 8, 16'hABCA, 16'hBCAB, 16'hCABC};
    vecs[1] = '{8'd0, 12'h123, 8'h77, 8'h66, 3, 8, 16'h1231, 16'h2312, 16'h3123};
    vecs[2] = '{8'd0, 12'hFFF, 8'h00, 8'h00, 3, 8, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{8'd1, 12'h000, 8'h5A, 8'h11, 3, 5, 16'h5A5A, 16'h5A5A, 16'h5A5A};
    vecs[4] = '{8'd2, 12'h000, 8'h5A, 8'h3C, 3, 5, 16'h3C3C, 16'h3C3C, 16'h3C3C};
    vecs[5] = '{8'd5, 12'hABC, 8'h5A, 8'h3C, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[6] = '{8'hFF, 12'h123, 8'h5A, 8'h3C, 0, 0, 16'h0000, 16'h0000, 16'h0000};

    rst_n = 1'b0;
    bus.q_samples = '0; bus.ch1_i = '0; bus.ch1_q = '0; bus.mode = '0; bus.enable = 1'b0;
    do_reset();
    chk("reset_data", bus.source_data, 0);
    chk("reset_en", bus.source_en, 0);
    chk("reset_end", bus.source_packet_end, 0);
    chk("reset_amode", bus.active_mode, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pcount", bus.packet_count, 0);

    // Constant-input vectors: latency, word rate and packing order.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      bus.q_samples = vecs[v].q; bus.ch1_i = vecs[v].ri; bus.ch1_q = vecs[v].rq;
      bus.mode = vecs[v].mode; bus.enable = 1'b1;
      first = 0; n = 0; got[0] = '0; got[1] = '0; got[2] = '0;
      for (int c = 1; c <= 12; c++) begin
        step();
        if (bus.source_en) begin
          if (n == 0) first = c;
          if (n < 3) got[n] = bus.source_data;
          n++;
        end
      end
      chk($sformatf("vec%0d_first_en", v), first, vecs[v].first);
      chk($sformatf("vec%0d_word_count", v), n, vecs[v].cnt);
      if (vecs[v].cnt > 0) begin
        chk($sformatf("vec%0d_w0", v), got[0], vecs[v].w0);
        chk($sformatf("vec%0d_w1", v), got[1], vecs[v].w1);
        chk($sformatf("vec%0d_w2", v), got[2], vecs[v].w2);
      end
      $display("vector %0d: mode=%0d words=%0d first_en=%0d", v, vecs[v].mode, n, first);
    end

    // Full mode-0 packet, then back-to-back continuation.
    do_reset();
    bus.mode = 8'd0; bus.q_samples = 12'hABC; bus.enable = 1'b1;
    step();
    run_until_end(1200, endw);
    chk("t2_end_word", endw, 720);
    chk("t2_pkt_count", bus.packet_count, 1);
    step();
    chk("t2_busy_no_gap", bus.busy, 1);
    chk("t2_gap_en", bus.source_en, 0);
    step();
    chk("t2_next_en", bus.source_en, 1);
    chk("t2_next_data", bus.source_data, 16'hABCA);
    $display("seq t2: mode0 packet end at word %0d", endw);

    // Mode 1 ramp on ch1_i.
    do_reset();
    bus.mode = 8'd1; bus.enable = 1'b1; bus.ch1_i = 8'hEE;
    step();
    endw = -1; n = 0; w0 = '0; w1 = '0;
    for (int i = 0; i < 1600; i++) begin
      bus.ch1_i = 8'(i);
      step();
      n++;
      if (bus.source_en && word_cnt == 1) w0 = bus.source_data;
      if (bus.source_en && word_cnt == 2) w1 = bus.source_data;
      if (bus.source_en && bus.source_packet_end) begin
        endw = word_cnt;
        break;
      end
    end
    chk("t3_w0", w0, 16'h0001);
    chk("t3_w1", w1, 16'h0203);
    chk("t3_end_word", endw, 720);
    chk("t3_samples", n, 1440);
    $display("seq t3: mode1 ramp packet end at word %0d after %0d samples", endw, n);

    // Mode change mid-packet takes effect only at the boundary.
    do_reset();
    bus.mode = 8'd1; bus.enable = 1'b1;
    step();
    for (int i = 0; i < 1600 && word_cnt < 300; i++) begin
      bus.ch1_i = 8'($urandom); bus.ch1_q = 8'($urandom);
      step();
    end
    chk("t4_reach_300", word_cnt, 300);
    bus.mode = 8'd2;
    for (int i = 0; i < 1600 && word_cnt < 719; i++) begin
      bus.ch1_i = 8'($urandom); bus.ch1_q = 8'($urandom);
      step();
    end
    chk("t4_amode_before_end", bus.active_mode, 1);
    endw = -1;
    for (int i = 0; i < 10; i++) begin
      bus.ch1_i = 8'($urandom); bus.ch1_q = 8'($urandom);
      step();
      if (bus.source_en && bus.source_packet_end) begin
        endw = word_cnt;
        break;
      end
    end
    chk("t4_end_word", endw, 720);
    chk("t4_amode_after_end", bus.active_mode, 2);
    for (int i = 0; i < 20; i++) begin
      bus.ch1_i = 8'($urandom); bus.ch1_q = 8'($urandom);
      step();
    end
    $display("seq t4: mode switch at word 300, boundary at word %0d", endw);

    // Enable dropped mid-packet: packet completes, then idle.
    do_reset();
    bus.mode = 8'd0; bus.enable = 1'b1; bus.q_samples = 12'(($urandom));
    step();
    run_until_words("t5_reach_100", 100, 200);
    bus.enable = 1'b0;
    run_until_end(1200, endw);
    chk("t5_end_word", endw, 720);
    chk("t5_pkt_count", bus.packet_count, 1);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.source_en) en_cnt++;
    end
    chk("t5_idle_en", en_cnt, 0);
    chk("t5_idle_busy", bus.busy, 0);
    $display("seq t5: enable drop, packet end at word %0d", endw);

    // Reset mid-packet, then an invalid mode request.
    do_reset();
    bus.mode = 8'd0; bus.enable = 1'b1; bus.q_samples = 12'h5A3;
    step();
    run_until_words("t6_reach_500", 500, 800);
    rst_n = 1'b0;
    step();
    chk("t6_data", bus.source_data, 0);
    chk("t6_en", bus.source_en, 0);
    chk("t6_end", bus.source_packet_end, 0);
    chk("t6_amode", bus.active_mode, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_pcount", bus.packet_count, 0);
    rst_n = 1'b1;
    bus.mode = 8'd5;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.source_en) en_cnt++;
    end
    chk("t6_bad_mode_en", en_cnt, 0);
    chk("t6_bad_mode_busy", bus.busy, 0);
    $display("seq t6: reset at word 500, mode 5 stays idle");

    // Randomized traffic against the reference model.
    modes[0] = 8'd0; modes[1] = 8'd1; modes[2] = 8'd2; modes[3] = 8'd3; modes[4] = 8'd9;
    do_reset();
    bus.enable = 1'b1; bus.mode = 8'd0;
    for (int i = 0; i < 9000; i++) begin
      bus.q_samples = 12'($urandom);
      bus.ch1_i = 8'($urandom);
      bus.ch1_q = 8'($urandom);
      if ($urandom_range(0, 199) == 0) bus.mode = modes[$urandom_range(0, 4)];
      if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
      rst_n = ($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst_n = 1'b1;
    $display("random phase: packets=%0d", bus.packet_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
